// File: rtl/cache_arbiter_if.sv
// Bundle of icache, dcache and pmem signals shared by the arbiter and its clients.
// master is the arbiter's view; slave is the caches/pmem side.
interface cache_arbiter_if;
   logic          i_read;
   logic [31:0]   i_address;
   logic [255:0]  i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [31:0]   d_address;
   logic [255:0]  d_wdata;
   logic [255:0]  d_rdata;
   logic          d_resp;
   logic          pmem_resp;
   logic [63:0]   pmem_rdata;
   logic          pmem_read;
   logic          pmem_write;
   logic [31:0]   pmem_address;
   logic [63:0]   pmem_wdata;

   modport master (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_resp, pmem_rdata,
      output i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport slave (
      output i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_resp, pmem_rdata,
      input  i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto a single 64-bit pmem
// port as 4-beat bursts; contested grants alternate between the two caches.
module cache_arbiter #(
   parameter int BEATS = 4   // only 4 beats per 256-bit line is supported
) (
   input  logic             clk,
   input  logic             rst,
   cache_arbiter_if.master  bus
);

   typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} state_t;

   state_t        r_state;
   logic [1:0]    r_cnt;
   logic [255:0]  r_buf;
   logic          r_tie_d;      // dcache wins the next contested grant
   logic [31:0]   r_addr;
   logic          r_pmem_read;
   logic          r_pmem_write;
   logic          r_i_resp;
   logic          r_d_resp;

   logic          w_i_req;
   logic          w_d_req;
   logic          w_grant_d;

   always_comb begin
      w_i_req   = bus.i_read;
      w_d_req   = bus.d_read | bus.d_write;
      w_grant_d = w_d_req & (~w_i_req | r_tie_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_cnt        <= 2'd0;
         r_buf        <= '0;
         r_tie_d      <= 1'b0;
         r_addr       <= '0;
         r_pmem_read  <= 1'b0;
         r_pmem_write <= 1'b0;
         r_i_resp     <= 1'b0;
         r_d_resp     <= 1'b0;
      end else begin
         r_i_resp <= 1'b0;
         r_d_resp <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_i_req | w_d_req) begin
                  // only a contested grant moves the tie-break
                  if (w_i_req & w_d_req)
                     r_tie_d <= ~w_grant_d;
                  r_cnt <= 2'd0;
                  if (w_grant_d) begin
                     r_addr <= bus.d_address & 32'hFFFF_FFE0;
                     if (bus.d_write) begin
                        r_state      <= D_WRITE;
                        r_pmem_write <= 1'b1;
                     end else begin
                        r_state     <= D_READ;
                        r_pmem_read <= 1'b1;
                     end
                  end else begin
                     r_state     <= I_READ;
                     r_addr      <= bus.i_address & 32'hFFFF_FFE0;
                     r_pmem_read <= 1'b1;
                  end
               end
            end
            I_READ, D_READ, D_WRITE: begin
               if (bus.pmem_resp) begin
                  r_cnt <= r_cnt + 2'd1;
                  if (r_state != D_WRITE)
                     r_buf[{r_cnt, 6'd0} +: 64] <= bus.pmem_rdata;
                  if (r_cnt == 2'(BEATS - 1)) begin
                     r_state      <= DONE;
                     r_pmem_read  <= 1'b0;
                     r_pmem_write <= 1'b0;
                     r_addr       <= '0;
                     r_i_resp     <= (r_state == I_READ);
                     r_d_resp     <= (r_state != I_READ);
                  end
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.i_rdata      = r_buf;
   assign bus.d_rdata      = r_buf;
   assign bus.i_resp       = r_i_resp;
   assign bus.d_resp       = r_d_resp;
   assign bus.pmem_read    = r_pmem_read;
   assign bus.pmem_write   = r_pmem_write;
   assign bus.pmem_address = r_addr;
   assign bus.pmem_wdata   = (r_state == D_WRITE) ? bus.d_wdata[{r_cnt, 6'd0} +: 64] : 64'd0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized scoreboard bench for cache_arbiter: a driver predicts grant order and
// line contents at transaction level; negedge monitors compare pmem bursts and resps.
module tb_cache_arbiter;

   typedef struct {
      bit            side_d;
      bit            wr;
      logic [31:0]   addr;
      logic [255:0]  data;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   cache_arbiter_if bus();

   cache_arbiter #(.BEATS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   txn_t exp_cmd_q[$];
   txn_t exp_resp_q[$];
   bit   tie_d      = 1'b0;   // model: dcache wins the next tie
   bit   fixed_pat  = 1'b0;
   bit   rnd_delay  = 1'b0;
   bit   stall_mode = 1'b0;
   int   pm_beat    = 0;
   int   delay_left = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [63:0] beat_data(input logic [31:0] a, input int k);
      logic [3:0]  n;
      logic [31:0] kk;
      n  = 4'(k + 1);
      kk = k;
      if (fixed_pat) return {16{n}};
      return {a ^ (32'h0101_0101 * kk), ~a + kk};
   endfunction

   function automatic logic [255:0] exp_line(input logic [31:0] a);
      logic [255:0] l;
      logic [31:0]  al;
      al = a & 32'hFFFF_FFE0;
      for (int k = 0; k < 4; k++) l[k*64 +: 64] = beat_data(al, k);
      return l;
   endfunction

   // pmem: one beat pulse per cycle while a command is up, with optional gaps
   initial begin
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            bus.pmem_resp = 1'b0;
            pm_beat       = 0;
            delay_left    = 0;
         end else begin
            #1;
            bus.pmem_resp = 1'b0;
            if (rst && (bus.pmem_read || bus.pmem_write)) begin
               if (delay_left > 0) delay_left--;
               else begin
                  bus.pmem_resp  = 1'b1;
                  bus.pmem_rdata = beat_data(bus.pmem_address, pm_beat);
                  pm_beat        = (pm_beat + 1) % 4;
                  if (stall_mode && pm_beat == 1) delay_left = 10;
                  else if (rnd_delay)             delay_left = $urandom_range(0, 2);
                  else                            delay_left = 0;
               end
            end
         end
      end
   end

   // burst monitor
   txn_t cur;
   bit   in_burst  = 1'b0;
   bit   prev_cmd  = 1'b0;
   int   mon_beats = 0;

   always @(negedge clk) begin
      if (!rst) begin
         in_burst = 1'b0;
         prev_cmd = 1'b0;
      end else begin
         if ((bus.pmem_read || bus.pmem_write) && !prev_cmd) begin
            if (exp_cmd_q.size() == 0) begin
               fail("unexpected_burst");
               in_burst = 1'b0;
            end else begin
               cur       = exp_cmd_q.pop_front();
               in_burst  = 1'b1;
               mon_beats = 0;
            end
         end
         if (in_burst && (bus.pmem_read || bus.pmem_write)) begin
            check("pmem_address", bus.pmem_address, cur.addr & 32'hFFFF_FFE0);
            check("pmem_cmd", {bus.pmem_read, bus.pmem_write}, {~cur.wr, cur.wr});
            if (bus.pmem_resp) begin
               if (cur.wr) check("pmem_wdata", bus.pmem_wdata, cur.data[mon_beats*64 +: 64]);
               mon_beats++;
            end
         end
         if (!bus.pmem_read && !bus.pmem_write)
            check("idle_address_zero", bus.pmem_address, 0);
         if (!bus.pmem_write)
            check("wdata_zero_outside_write", bus.pmem_wdata, 0);
         prev_cmd = bus.pmem_read || bus.pmem_write;
      end
   end

   // response monitor
   always @(negedge clk) begin
      txn_t e;
      if (rst && (bus.i_resp || bus.d_resp)) begin
         if (exp_resp_q.size() == 0) fail("unexpected_resp");
         else begin
            e = exp_resp_q.pop_front();
            check("resp_side", {bus.i_resp, bus.d_resp}, {~e.side_d, e.side_d});
            check("resp_after_4_beats", mon_beats, 4);
            check("rdata_ports_equal", bus.i_rdata, bus.d_rdata);
            if (!e.wr) check("line_rdata", e.side_d ? bus.d_rdata : bus.i_rdata, e.data);
         end
      end
   end

   task automatic do_round(input bit ir, input logic [1:0] dk, input logic [31:0] ia,
                           input logic [31:0] da, input logic [255:0] wd, input bit early_drop);
      txn_t ti, td;
      bit   have_d, wait_i, wait_d;
      have_d    = (dk != 2'd0);
      ti.side_d = 1'b0; ti.wr = 1'b0;  ti.addr = ia; ti.data = exp_line(ia);
      td.side_d = 1'b1; td.wr = dk[1]; td.addr = da; td.data = dk[1] ? wd : exp_line(da);
      if (ir && have_d) begin
         if (tie_d) begin exp_cmd_q.push_back(td); exp_cmd_q.push_back(ti);
                          exp_resp_q.push_back(td); exp_resp_q.push_back(ti); tie_d = 1'b0; end
         else       begin exp_cmd_q.push_back(ti); exp_cmd_q.push_back(td);
                          exp_resp_q.push_back(ti); exp_resp_q.push_back(td); tie_d = 1'b1; end
      end else if (ir) begin
         exp_cmd_q.push_back(ti); exp_resp_q.push_back(ti);
      end else begin
         exp_cmd_q.push_back(td); exp_resp_q.push_back(td);
      end
      @(negedge clk);
      bus.i_read = ir;    bus.i_address = ia;
      bus.d_read = dk[0]; bus.d_write   = dk[1];
      bus.d_address = da; bus.d_wdata   = wd;
      wait_i = ir;
      wait_d = have_d;
      for (int c = 0; c < 300 && (wait_i || wait_d); c++) begin
         @(negedge clk);
         // a request dropped after its grant must still complete
         if (early_drop && c == 0 && !(ir && have_d)) begin
            bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
         end
         if (bus.i_resp) begin bus.i_read = 1'b0; wait_i = 1'b0; end
         if (bus.d_resp) begin bus.d_read = 1'b0; bus.d_write = 1'b0; wait_d = 1'b0; end
      end
      if (wait_i || wait_d) fail("round_timeout");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t td;
      logic [1:0]  dk;
      bit          ir;
      bus.i_read = 1'b0; bus.i_address = '0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_pmem_read",    bus.pmem_read, 0);
      check("rst_pmem_write",   bus.pmem_write, 0);
      check("rst_pmem_address", bus.pmem_address, 0);
      check("rst_pmem_wdata",   bus.pmem_wdata, 0);
      check("rst_resps",        {bus.i_resp, bus.d_resp}, 0);
      check("rst_i_rdata",      bus.i_rdata, 0);
      check("rst_d_rdata",      bus.d_rdata, 0);
      rst = 1'b1;

      // same-cycle i/d reads twice after reset: icache then dcache wins
      do_round(1'b1, 2'd1, 32'h0000_0040, 32'h0000_0080, '0, 1'b0);
      do_round(1'b1, 2'd1, 32'h0000_0100, 32'h0000_0200, '0, 1'b0);

      fixed_pat = 1'b1;
      do_round(1'b1, 2'd0, 32'h0000_1234, '0, '0, 1'b0);
      check("icache_line_fixed", bus.i_rdata,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
      fixed_pat = 1'b0;

      do_round(1'b0, 2'd2, 32'h8000_00E0, '0, {64'd4, 64'd3, 64'd2, 64'd1}, 1'b0);
      do_round(1'b0, 2'd3, 32'h0000_0A1F, '0, {4{64'hDEAD_BEEF_0BAD_F00D}}, 1'b0);

      stall_mode = 1'b1;
      do_round(1'b1, 2'd0, 32'h0000_5678, '0, '0, 1'b0);
      stall_mode = 1'b0;

      rnd_delay = 1'b1;
      for (int r = 0; r < 40; r++) begin
         ir = 1'($urandom_range(0, 1));
         dk = 2'($urandom_range(0, 3));
         if (!ir && dk == 2'd0) ir = 1'b1;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_round(ir, dk, $urandom, $urandom, {8{$urandom}}, $urandom_range(0, 3) == 0);
      end
      rnd_delay = 1'b0;

      // reset in the middle of a dcache fill, request still held afterwards
      td.side_d = 1'b1; td.wr = 1'b0; td.addr = 32'h0000_3300; td.data = exp_line(32'h0000_3300);
      exp_cmd_q.push_back(td);
      exp_resp_q.push_back(td);
      @(negedge clk);
      bus.d_read = 1'b1; bus.d_address = td.addr;
      for (int c = 0; c < 50 && pm_beat != 2; c++) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("async_rst_pmem_read", bus.pmem_read, 0);
      check("async_rst_address",   bus.pmem_address, 0);
      check("async_rst_d_rdata",   bus.d_rdata, 0);
      exp_cmd_q.delete();
      exp_resp_q.delete();
      tie_d = 1'b0;
      exp_cmd_q.push_back(td);
      exp_resp_q.push_back(td);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      begin
         bit got;
         got = 1'b0;
         for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (bus.d_resp) begin got = 1'b1; bus.d_read = 1'b0; end
         end
         if (!got) fail("post_reset_refill_timeout");
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_resp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
